// File: rtl/dpram_arb_pkg.sv
// Shared defaults and the port-select type for the dual-port RAM arbiter.
package dpram_arb_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned AW_DEF   = 6;
  localparam int unsigned DW_DEF   = 8;

  typedef enum logic [1:0] {
    PORT_A    = 2'd0,
    PORT_B    = 2'd1,
    PORT_NONE = 2'd2
  } port_sel_e;

endpackage

// File: rtl/rr_find_first.sv
// Finds the first set bit of req at or after index start, wrapping modulo N.
module rr_find_first #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  int pos;

  // Scan from the far end of the search order so the nearest hit overwrites.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      pos = int'(start) + k;
      if (pos >= int'(N)) pos = pos - int'(N);
      if (req[pos]) begin
        found = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter mapping NREQ requesters onto the two ports of a dual-port RAM.
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rd_valid,
  output logic [NREQ*DW-1:0] rd_data,
  output logic [AW-1:0]      addr_a,
  output logic [AW-1:0]      addr_b,
  output logic [DW-1:0]      data_a,
  output logic [DW-1:0]      data_b,
  output logic               we_a,
  output logic               we_b,
  input  logic [DW-1:0]      q_a,
  input  logic [DW-1:0]      q_b
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   ptr_q, ptr_d;
  logic            a_found, b_found;
  logic [IW-1:0]   a_idx, b_idx;
  logic [NREQ-1:0] a_mask, b_cand;
  logic [AW-1:0]   a_addr, b_addr;
  logic [DW-1:0]   a_data, b_data;
  logic            b_conflict;
  logic            a_gnt, b_gnt;
  port_sel_e       last_sel;

  logic            tag_a_vld_q, tag_b_vld_q;
  logic [IW-1:0]   tag_a_idx_q, tag_b_idx_q;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] i);
    return (32'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_find_first #(
    .N  (NREQ),
    .IW (IW)
  ) u_find_a (
    .req   (req),
    .start (ptr_q),
    .found (a_found),
    .idx   (a_idx)
  );

  always_comb begin
    a_mask        = '0;
    a_mask[a_idx] = a_found;
  end

  assign b_cand = req & ~a_mask;

  // With the A winner removed, the first hit from ptr is the next one after A.
  rr_find_first #(
    .N  (NREQ),
    .IW (IW)
  ) u_find_b (
    .req   (b_cand),
    .start (ptr_q),
    .found (b_found),
    .idx   (b_idx)
  );

  assign a_addr = req_addr[a_idx*AW +: AW];
  assign b_addr = req_addr[b_idx*AW +: AW];
  assign a_data = req_wdata[a_idx*DW +: DW];
  assign b_data = req_wdata[b_idx*DW +: DW];

  // Same-address pairs are only safe when both sides read.
  assign b_conflict = (a_addr == b_addr) && (req_we[a_idx] || req_we[b_idx]);

  assign a_gnt = a_found && !rst;
  assign b_gnt = b_found && !b_conflict && !rst;

  always_comb begin
    gnt    = '0;
    we_a   = 1'b0;
    addr_a = '0;
    data_a = '0;
    we_b   = 1'b0;
    addr_b = '0;
    data_b = '0;
    if (a_gnt) begin
      gnt[a_idx] = 1'b1;
      we_a       = req_we[a_idx];
      addr_a     = a_addr;
      data_a     = a_data;
    end
    if (b_gnt) begin
      gnt[b_idx] = 1'b1;
      we_b       = req_we[b_idx];
      addr_b     = b_addr;
      data_b     = b_data;
    end
  end

  always_comb begin
    if (b_gnt)      last_sel = PORT_B;
    else if (a_gnt) last_sel = PORT_A;
    else            last_sel = PORT_NONE;

    ptr_d = ptr_q;
    unique case (last_sel)
      PORT_A:  ptr_d = inc_wrap(a_idx);
      PORT_B:  ptr_d = inc_wrap(b_idx);
      default: ptr_d = ptr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      tag_a_vld_q <= 1'b0;
      tag_a_idx_q <= '0;
      tag_b_vld_q <= 1'b0;
      tag_b_idx_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      tag_a_vld_q <= a_gnt && !req_we[a_idx];
      tag_a_idx_q <= a_idx;
      tag_b_vld_q <= b_gnt && !req_we[b_idx];
      tag_b_idx_q <= b_idx;
    end
  end

  // Return path: route each port's RAM output to the requester tagged last cycle.
  always_comb begin
    rd_valid = '0;
    rd_data  = '0;
    if (!rst) begin
      if (tag_a_vld_q) begin
        rd_valid[tag_a_idx_q]             = 1'b1;
        rd_data[tag_a_idx_q*DW +: DW]     = q_a;
      end
      if (tag_b_vld_q) begin
        rd_valid[tag_b_idx_q]             = 1'b1;
        rd_data[tag_b_idx_q*DW +: DW]     = q_b;
      end
    end
  end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed self-checking bench for dpram_arbiter with a small registered-read RAM model.
module tb_dpram_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 6;
  localparam int unsigned DW   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req, req_we, gnt, rd_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata, rd_data;
  logic [AW-1:0]      addr_a, addr_b;
  logic [DW-1:0]      data_a, data_b, q_a, q_b;
  logic               we_a, we_b;

  int checks   = 0;
  int failures = 0;

  dpram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .data_a    (data_a),
    .data_b    (data_b),
    .we_a      (we_a),
    .we_b      (we_b),
    .q_a       (q_a),
    .q_b       (q_b)
  );

  always #5 clk = ~clk;

  // RAM preloaded with addr ^ 8'h5A, one-cycle read latency.
  logic [DW-1:0] mem [0:63];
  logic          init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i) ^ 8'h5A;
      init_done <= 1'b1;
    end else begin
      if (we_a) mem[addr_a] <= data_a;
      if (we_b) mem[addr_b] <= data_b;
    end
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; req_we = 4'b1111;
    req_addr = {6'd7, 6'd6, 6'd5, 6'd4}; req_wdata = 32'hA1B2C3D4;
    #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rst_gnt got=%b want=0000", gnt); end
    checks++; if ({we_a, we_b} !== 2'b00) begin failures++; $display("FAIL rst_we got=%b want=00", {we_a, we_b}); end
    checks++; if ({addr_a, addr_b, data_a, data_b} !== '0) begin failures++; $display("FAIL rst_ports got=%h want=0", {addr_a, addr_b, data_a, data_b}); end
    cycle();
    checks++; if (rd_valid !== 4'b0000 || rd_data !== '0) begin failures++; $display("FAIL rst_rd got=%b/%h want=0/0", rd_valid, rd_data); end
  endtask

  task automatic test_single_write();
    do_reset();
    req = 4'b0001; req_we = 4'b0001; req_addr[0 +: AW] = 6'd1; req_wdata[0 +: DW] = 8'h0A;
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL w1_gnt got=%b want=0001", gnt); end
    checks++; if ({we_a, addr_a, data_a} !== {1'b1, 6'd1, 8'h0A}) begin failures++; $display("FAIL w1_porta got=%b/%h/%h want=1/01/0a", we_a, addr_a, data_a); end
    checks++; if ({we_b, addr_b, data_b} !== '0) begin failures++; $display("FAIL w1_portb got=%b/%h/%h want=0/0/0", we_b, addr_b, data_b); end
    // ptr is now 1, so requester 1 wins port A.
    cycle();
    req = 4'b0011; req_we = 4'b0000; req_addr[0 +: AW] = 6'd20; req_addr[AW +: AW] = 6'd21;
    #1;
    checks++; if (gnt !== 4'b0011) begin failures++; $display("FAIL w1_ptr_gnt got=%b want=0011", gnt); end
    checks++; if ({addr_a, addr_b} !== {6'd21, 6'd20}) begin failures++; $display("FAIL w1_ptr_addr got=%0d/%0d want=21/20", addr_a, addr_b); end
    cycle();
    req = '0;
    #1;
    checks++; if (rd_valid !== 4'b0011) begin failures++; $display("FAIL w1_rdv got=%b want=0011", rd_valid); end
    checks++; if (rd_data[15:0] !== 16'h4F4E) begin failures++; $display("FAIL w1_rdd got=%h want=4f4e", rd_data[15:0]); end
  endtask

  task automatic test_same_addr_reads();
    do_reset();
    req = 4'b0011; req_we = 4'b0000; req_addr[0 +: AW] = 6'd10; req_addr[AW +: AW] = 6'd10;
    #1;
    checks++; if (gnt !== 4'b0011) begin failures++; $display("FAIL rr_gnt got=%b want=0011", gnt); end
    checks++; if ({addr_a, addr_b, we_a, we_b} !== {6'd10, 6'd10, 2'b00}) begin failures++; $display("FAIL rr_ports got=%0d/%0d/%b%b want=10/10/00", addr_a, addr_b, we_a, we_b); end
    cycle();
    req = '0;
    #1;
    checks++; if (rd_valid !== 4'b0011) begin failures++; $display("FAIL rr_rdv got=%b want=0011", rd_valid); end
    checks++; if (rd_data !== 32'h00005050) begin failures++; $display("FAIL rr_rdd got=%h want=00005050", rd_data); end
    cycle();
    checks++; if (rd_valid !== 4'b0000 || rd_data !== '0) begin failures++; $display("FAIL rr_once got=%b/%h want=0/0", rd_valid, rd_data); end
  endtask

  task automatic test_conflict();
    do_reset();
    req = 4'b0011; req_we = 4'b0001;
    req_addr[0 +: AW] = 6'd15; req_addr[AW +: AW] = 6'd15; req_wdata[0 +: DW] = 8'hC3;
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL wr_gnt got=%b want=0001", gnt); end
    checks++; if ({we_a, data_a, we_b} !== {1'b1, 8'hC3, 1'b0}) begin failures++; $display("FAIL wr_ports got=%b/%h/%b want=1/c3/0", we_a, data_a, we_b); end
    cycle();
    req = 4'b0010; req_we = 4'b0000;
    #1;
    checks++; if (gnt !== 4'b0010 || addr_a !== 6'd15 || we_a !== 1'b0) begin failures++; $display("FAIL wr_retry got=%b/%0d/%b want=0010/15/0", gnt, addr_a, we_a); end
    checks++; if (rd_valid !== 4'b0000) begin failures++; $display("FAIL wr_nordv got=%b want=0000", rd_valid); end
    cycle();
    req = '0;
    #1;
    checks++; if (rd_valid !== 4'b0010 || rd_data[DW +: DW] !== 8'hC3) begin failures++; $display("FAIL wr_raw got=%b/%h want=0010/c3", rd_valid, rd_data[DW +: DW]); end
    // Read on A with a write on B to the same address is also withheld.
    do_reset();
    req = 4'b0011; req_we = 4'b0010; req_addr[0 +: AW] = 6'd5; req_addr[AW +: AW] = 6'd5;
    #1;
    checks++; if (gnt !== 4'b0001 || we_b !== 1'b0) begin failures++; $display("FAIL rw_gnt got=%b/%b want=0001/0", gnt, we_b); end
    do_reset();
    req = 4'b0011; req_we = 4'b0011; req_addr[0 +: AW] = 6'd2; req_addr[AW +: AW] = 6'd3;
    req_wdata[0 +: DW] = 8'h11; req_wdata[DW +: DW] = 8'h22;
    #1;
    checks++; if (gnt !== 4'b0011) begin failures++; $display("FAIL ww_gnt got=%b want=0011", gnt); end
    checks++; if ({we_b, addr_b, data_b} !== {1'b1, 6'd3, 8'h22}) begin failures++; $display("FAIL ww_portb got=%b/%0d/%h want=1/3/22", we_b, addr_b, data_b); end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0100; req_we = 4'b0000; req_addr[2*AW +: AW] = 6'd7;
    #1;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL wrap_g0 got=%b want=0100", gnt); end
    cycle();
    req = 4'b1001; req_addr[0 +: AW] = 6'd3; req_addr[3*AW +: AW] = 6'd9;
    #1;
    checks++; if (gnt !== 4'b1001 || addr_a !== 6'd9 || addr_b !== 6'd3) begin failures++; $display("FAIL wrap_g1 got=%b/%0d/%0d want=1001/9/3", gnt, addr_a, addr_b); end
    cycle();
    req = 4'b0011; req_addr[AW +: AW] = 6'd4;
    #1;
    checks++; if (addr_a !== 6'd4 || addr_b !== 6'd3) begin failures++; $display("FAIL wrap_g2 got=%0d/%0d want=4/3", addr_a, addr_b); end
    checks++; if (rd_valid !== 4'b1001) begin failures++; $display("FAIL wrap_rdv got=%b want=1001", rd_valid); end
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] exp_g, prev_g;
    logic [DW-1:0]   exp_d;
    prev_g = '0;
    do_reset();
    req = 4'b1111; req_we = 4'b0000;
    for (int i = 0; i < 4; i++) req_addr[i*AW +: AW] = 6'(30 + i);
    for (int c = 0; c < 5; c++) begin
      #1;
      exp_g = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      checks++; if (gnt !== exp_g) begin failures++; $display("FAIL b2b_gnt c=%0d got=%b want=%b", c, gnt, exp_g); end
      checks++; if (addr_a !== ((c % 2 == 0) ? 6'd30 : 6'd32)) begin failures++; $display("FAIL b2b_addr c=%0d got=%0d want=%0d", c, addr_a, (c % 2 == 0) ? 30 : 32); end
      if (c > 0) begin
        checks++; if (rd_valid !== prev_g) begin failures++; $display("FAIL b2b_rdv c=%0d got=%b want=%b", c, rd_valid, prev_g); end
        for (int i = 0; i < 4; i++) begin
          exp_d = prev_g[i] ? (8'(30 + i) ^ 8'h5A) : 8'h00;
          checks++; if (rd_data[i*DW +: DW] !== exp_d) begin failures++; $display("FAIL b2b_rdd c=%0d i=%0d got=%h want=%h", c, i, rd_data[i*DW +: DW], exp_d); end
        end
      end
      prev_g = exp_g;
      cycle();
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0001; req_we = 4'b0000; req_addr[0 +: AW] = 6'd10;
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL mid_gnt got=%b want=0001", gnt); end
    cycle();
    rst = 1'b1; req = 4'b1111; req_we = 4'b1111;
    req_addr = {6'd1, 6'd2, 6'd3, 6'd4}; req_wdata = 32'h55667788;
    #1;
    checks++; if (rd_valid !== 4'b0000 || rd_data !== '0) begin failures++; $display("FAIL mid_rd got=%b/%h want=0/0", rd_valid, rd_data); end
    checks++; if (gnt !== 4'b0000 || {we_a, we_b} !== 2'b00) begin failures++; $display("FAIL mid_gnt_rst got=%b/%b%b want=0000/00", gnt, we_a, we_b); end
    checks++; if ({addr_a, addr_b, data_a, data_b} !== '0) begin failures++; $display("FAIL mid_ports got=%h want=0", {addr_a, addr_b, data_a, data_b}); end
    cycle();
    rst = 1'b0; req = '0; req_we = '0;
    #1;
    checks++; if (rd_valid !== 4'b0000) begin failures++; $display("FAIL mid_after got=%b want=0000", rd_valid); end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    cycle();
    test_reset();
    test_single_write();
    test_same_addr_reads();
    test_conflict();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
